edge_event_arbiter: RTL and testbench

Multi-channel level-to-event scheduler. Each of N synchronous level inputs is converted to a single rising-edge event. Pending events from all channels share one downstream event port through a round-robin arbiter with a valid/ready handshake. It sits between level-type status sources (already synchronised to `clk`) and a single consumer that services one channel event at a time.

---
 rtl/edge_event_arbiter.sv | 93 +++++++++
 tb/tb_edge_event_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Converts N level inputs to rising-edge events and offers them one at a time, round-robin.
// Latency: a rise sampled at edge k sets pending after edge k; event_valid follows after edge k+1.
// Backpressure: an offer is held stable until event_ready; further edges on a pending channel set overflow.
module edge_event_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   level_in,
    output logic           event_valid,
    output logic [IDW-1:0] event_id,
    input  logic           event_ready,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow,
    input  logic           overflow_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1
    } state_t;

    state_t         state;
    logic [N-1:0]   prev;
    logic [N-1:0]   rise;
    logic [N-1:0]   clear_vec;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] next_ptr;
    logic           found;
    logic           accept;

    assign rise      = level_in & ~prev;
    assign accept    = (state == OFFER) && event_valid && event_ready;
    assign clear_vec = accept ? (N'(1) << event_id) : '0;
    assign next_ptr  = (event_id == IDW'(N - 1)) ? '0 : event_id + IDW'(1);

    // First pending channel at or above rr_ptr, wrapping past N-1.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % N);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prev        <= '0;
            pending     <= '0;
            overflow    <= '0;
            rr_ptr      <= '0;
            event_valid <= 1'b0;
            event_id    <= '0;
        end else begin
            prev     <= level_in;
            // A rise landing on the accept cycle re-arms the channel without counting as overflow.
            pending  <= (pending & ~clear_vec) | rise;
            overflow <= (overflow_clr ? '0 : overflow) | (rise & pending & ~clear_vec);
            case (state)
                IDLE: begin
                    if (found) begin
                        event_id    <= pick;
                        event_valid <= 1'b1;
                        state       <= OFFER;
                    end else begin
                        event_valid <= 1'b0;
                    end
                end
                OFFER: begin
                    if (accept) begin
                        event_valid <= 1'b0;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE;
                    end
                end
                default: begin
                    event_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against a per-channel behavioural model.
module tb_edge_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   level_in;
    logic           event_valid;
    logic [IDW-1:0] event_id;
    logic           event_ready;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;
    logic           overflow_clr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [N-1:0] m_prev, m_pend, m_ovf;
    bit           m_valid;
    int           m_id, m_ptr;
    int           dut_grants[$];
    int           dut_grant_cyc[$];
    int           m_grants[$];

    edge_event_arbiter #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .level_in    (level_in),
        .event_valid (event_valid),
        .event_id    (event_id),
        .event_ready (event_ready),
        .pending     (pending),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 0;
        m_id    = 0;
        m_ptr   = 0;
        dut_grants.delete();
        dut_grant_cyc.delete();
        m_grants.delete();
    endtask

    // One clock of the behavioural model, using the state as it stood before the edge.
    task automatic model_step(input logic [N-1:0] lvl, input bit rdy, input bit clr);
        logic [N-1:0] np, no;
        bit acc, r, c, got;
        acc = m_valid && rdy;
        for (int i = 0; i < N; i++) begin
            r = lvl[i] && !m_prev[i];
            c = acc && (m_id == i);
            np[i] = r ? 1'b1 : (c ? 1'b0 : m_pend[i]);
            no[i] = (r && m_pend[i] && !c) ? 1'b1 : (clr ? 1'b0 : m_ovf[i]);
        end
        if (m_valid) begin
            if (acc) begin
                m_grants.push_back(m_id);
                m_valid = 0;
                m_ptr   = (m_id + 1) % N;
            end
        end else begin
            got = 0;
            for (int k = 0; k < N; k++) begin
                if (!got && m_pend[(m_ptr + k) % N]) begin
                    got     = 1;
                    m_id    = (m_ptr + k) % N;
                    m_valid = 1;
                end
            end
        end
        m_pend = np;
        m_ovf  = no;
        m_prev = lvl;
    endtask

    // Called at a falling edge: drive, clock, then compare at the next falling edge.
    task automatic step(input logic [N-1:0] lvl, input bit rdy, input bit clr);
        level_in     = lvl;
        event_ready  = rdy;
        overflow_clr = clr;
        if (event_valid && rdy) begin
            dut_grants.push_back(int'(event_id));
            dut_grant_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        model_step(lvl, rdy, clr);
        @(negedge clk);
        check("event_valid", 32'(event_valid), 32'(m_valid));
        check("event_id",    32'(event_id),    32'(m_id));
        check("pending",     32'(pending),     32'(m_pend));
        check("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        level_in     = '0;
        event_ready  = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset        = 1'b0;
        level_in     = '0;
        event_ready  = 1'b0;
        overflow_clr = 1'b0;
        #1;
        check("reset_valid",    32'(event_valid), 32'd0);
        check("reset_id",       32'(event_id),    32'd0);
        check("reset_pending",  32'(pending),     32'd0);
        check("reset_overflow", 32'(overflow),    32'd0);
        @(negedge clk);
        do_reset();

        // Single edge
        step(4'b0000, 0, 0);
        step(4'b0001, 0, 0);
        check("t1_pending_set", 32'(pending), 32'h1);
        check("t1_valid_clear", 32'(event_valid), 32'd0);
        step(4'b0001, 0, 0);
        check("t1_offer_valid", 32'(event_valid), 32'd1);
        check("t1_offer_id",    32'(event_id),    32'd0);
        step(4'b0001, 1, 0);
        check("t1_pending_clr", 32'(pending), 32'h0);
        for (int i = 0; i < 5; i++) step(4'b0001, 1, 0);
        check("t1_one_event", 32'(dut_grants.size()), 32'd1);

        // Round-robin with ready tied high
        do_reset();
        step(4'b0000, 1, 0);
        for (int i = 0; i < 9; i++) step(4'b1111, 1, 0);
        check("t2_grant_count", 32'(dut_grants.size()), 32'd4);
        for (int i = 0; i < dut_grants.size() && i < 4; i++) begin
            check("t2_grant_order", 32'(dut_grants[i]), 32'(i));
            if (i > 0) check("t2_grant_spacing", 32'(dut_grant_cyc[i] - dut_grant_cyc[i-1]), 32'd2);
        end
        step(4'b0000, 1, 0);
        dut_grants.delete();
        for (int i = 0; i < 6; i++) step(4'b1001, 1, 0);
        check("t2b_grant_count", 32'(dut_grants.size()), 32'd2);
        if (dut_grants.size() >= 2) begin
            check("t2b_first",  32'(dut_grants[0]), 32'd0);
            check("t2b_second", 32'(dut_grants[1]), 32'd3);
        end

        // Backpressure
        do_reset();
        step(4'b0100, 0, 0);
        step(4'b0100, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0110, 0, 0);
            check("t3_hold_valid", 32'(event_valid), 32'd1);
            check("t3_hold_id",    32'(event_id),    32'd2);
        end
        step(4'b0110, 1, 0);
        check("t3_drop_valid", 32'(event_valid), 32'd0);
        step(4'b0110, 0, 0);
        check("t3_next_valid", 32'(event_valid), 32'd1);
        check("t3_next_id",    32'(event_id),    32'd1);
        step(4'b0110, 1, 0);

        // Overflow
        do_reset();
        step(4'b1000, 0, 0);
        step(4'b1000, 0, 0);
        step(4'b0000, 0, 0);
        step(4'b1000, 0, 0);
        check("t4_overflow", 32'(overflow), 32'h8);
        check("t4_pending3", 32'(pending[3]), 32'd1);
        step(4'b1000, 1, 0);
        for (int i = 0; i < 4; i++) step(4'b1000, 1, 0);
        check("t4_one_event", 32'(dut_grants.size()), 32'd1);
        step(4'b1000, 0, 1);
        check("t4_ovf_clear", 32'(overflow), 32'h0);

        // Rise coincident with accept
        do_reset();
        step(4'b0010, 0, 0);
        step(4'b0010, 0, 0);
        step(4'b0000, 0, 0);
        step(4'b0010, 1, 0);
        check("t5_pending1",  32'(pending[1]),  32'd1);
        check("t5_overflow1", 32'(overflow[1]), 32'd0);
        step(4'b0010, 0, 0);
        check("t5_reoffer_valid", 32'(event_valid), 32'd1);
        check("t5_reoffer_id",    32'(event_id),    32'd1);
        step(4'b0010, 1, 0);

        // Reset mid-offer
        do_reset();
        step(4'b0001, 0, 0);
        step(4'b0001, 0, 0);
        check("t6_offering", 32'(event_valid), 32'd1);
        #2;
        reset    = 1'b0;
        level_in = 4'b0101;
        #1;
        check("t6_async_valid",   32'(event_valid), 32'd0);
        check("t6_async_id",      32'(event_id),    32'd0);
        check("t6_async_pending", 32'(pending),     32'd0);
        check("t6_async_ovf",     32'(overflow),    32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(4'b0101, 1, 0);
        check("t6_grant_count", 32'(dut_grants.size()), 32'd2);
        if (dut_grants.size() >= 2) begin
            check("t6_first",  32'(dut_grants[0]), 32'd0);
            check("t6_second", 32'(dut_grants[1]), 32'd2);
        end

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        check("rand_grant_total", 32'(dut_grants.size()), 32'(m_grants.size()));
        for (int i = 0; i < dut_grants.size() && i < m_grants.size(); i++) begin
            if (dut_grants[i] != m_grants[i]) check("rand_grant_seq", 32'(dut_grants[i]), 32'(m_grants[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
